l2cache_responder: RTL

- Responder end of the arbiter-to-L2 request/response interface.
- Accepts single-line read/write requests from the memory arbiter and services them from a direct-mapped, write-back line store.
- On a miss, fetches the line from physical memory; on a dirty miss, writes the victim back first.
- Sits between the arbiter (upstream) and the pmem port (downstream).

---
 rtl/l2cache_responder.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/l2cache_responder.sv
// l2cache_responder
//
// Responder end of the arbiter-to-L2 request/response interface. Services
// single-line read/write requests from a direct-mapped, write-back line store.
// A miss fetches the line from physical memory; a dirty miss first writes the
// victim line back. After a miss is filled the FSM returns to TAG_CHECK, which
// then hits and completes the request like any other hit.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   arbiter_l2cache_read/write    request strobes, held until resp
//   arbiter_l2cache_address       line address (bits [4:0] ignored)
//   arbiter_l2cache_wdata         full-line write data
//   l2cache_arbiter_rdata         read data, valid only in the resp cycle
//   l2cache_arbiter_resp          single-cycle completion pulse
//   pmem_read/pmem_write          line fetch / writeback request, held until pmem_resp
//   pmem_address, pmem_wdata      line-aligned pmem address and victim data
//   pmem_rdata, pmem_resp         fetched line and pmem completion pulse
//
// Optional feature: define L2_PERF_CNT_EN to add the saturating 32-bit
// hit_count / miss_count outputs. Without it those ports and counters are absent.

module l2cache_responder #(
  parameter int S_INDEX = 3,
  parameter int LINE_W  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arbiter_l2cache_read,
  input  logic              arbiter_l2cache_write,
  input  logic [31:0]       arbiter_l2cache_address,
  input  logic [LINE_W-1:0] arbiter_l2cache_wdata,
  output logic [LINE_W-1:0] l2cache_arbiter_rdata,
  output logic              l2cache_arbiter_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
`ifdef L2_PERF_CNT_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int SETS  = 1 << S_INDEX;
  localparam int TAG_W = 27 - S_INDEX;

  typedef enum logic [1:0] {
    IDLE,
    TAG_CHECK,
    WRITEBACK,
    FILL
  } state_e;

  state_e              state_q, state_d;
  logic [SETS-1:0]     valid_q, valid_d;
  logic [SETS-1:0]     dirty_q, dirty_d;
  logic [TAG_W-1:0]    tag_q  [SETS];
  logic [TAG_W-1:0]    tag_d  [SETS];
  logic [LINE_W-1:0]   line_q [SETS];
  logic [LINE_W-1:0]   line_d [SETS];

  logic [S_INDEX-1:0]  req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                req_valid;
  logic                req_is_write;
  logic                hit;
  logic                unused_offset;

  // Requests are held stable until resp, so the live address/data inputs are
  // used directly instead of being captured into a request register.
  assign req_idx       = arbiter_l2cache_address[5 +: S_INDEX];
  assign req_tag       = arbiter_l2cache_address[31 -: TAG_W];
  assign req_valid     = arbiter_l2cache_read | arbiter_l2cache_write;
  // Read and write asserted together is treated as a write.
  assign req_is_write  = arbiter_l2cache_write;
  assign hit           = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_offset = ^arbiter_l2cache_address[4:0];

  // Next-state, array-update and output logic. pmem outputs depend only on
  // the current state (plus the held request address), so they are stable for
  // the whole pmem transaction. resp is suppressed under reset so an aborted
  // request never completes.
  always_comb begin
    state_d               = state_q;
    valid_d               = valid_q;
    dirty_d               = dirty_q;
    tag_d                 = tag_q;
    line_d                = line_q;
    l2cache_arbiter_resp  = 1'b0;
    l2cache_arbiter_rdata = '0;
    pmem_read             = 1'b0;
    pmem_write            = 1'b0;
    pmem_address          = '0;
    pmem_wdata            = '0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = TAG_CHECK;
        end
      end

      TAG_CHECK: begin
        if (hit) begin
          l2cache_arbiter_resp = !rst;
          state_d              = IDLE;
          if (req_is_write) begin
            line_d[req_idx]  = arbiter_l2cache_wdata;
            dirty_d[req_idx] = 1'b1;
          end else begin
            l2cache_arbiter_rdata = line_q[req_idx];
          end
        end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
          state_d = WRITEBACK;
        end else begin
          state_d = FILL;
        end
      end

      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[req_idx], req_idx, 5'b0};
        pmem_wdata   = line_q[req_idx];
        if (pmem_resp) begin
          dirty_d[req_idx] = 1'b0;
          state_d          = FILL;
        end
      end

      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {arbiter_l2cache_address[31:5], 5'b0};
        if (pmem_resp) begin
          line_d[req_idx]  = pmem_rdata;
          tag_d[req_idx]   = req_tag;
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b0;
          state_d          = TAG_CHECK;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state and per-set valid/dirty bits; reset invalidates every line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data storage carry no reset; their contents are meaningless
  // until the matching valid bit is set by a fill.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    line_q <= line_d;
  end

`ifdef L2_PERF_CNT_EN
  logic        revisit_q, revisit_d;
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // revisit marks the TAG_CHECK that follows a fill, so each request is
  // classified exactly once, on its first lookup. Counters saturate.
  always_comb begin
    revisit_d    = revisit_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;

    if (state_q == IDLE) begin
      revisit_d = 1'b0;
    end else if (state_q == FILL && pmem_resp) begin
      revisit_d = 1'b1;
    end

    if (state_q == TAG_CHECK && !revisit_q) begin
      if (hit) begin
        if (hit_count_q != 32'hFFFF_FFFF) begin
          hit_count_d = hit_count_q + 32'd1;
        end
      end else begin
        if (miss_count_q != 32'hFFFF_FFFF) begin
          miss_count_d = miss_count_q + 32'd1;
        end
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      revisit_q    <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      revisit_q    <= revisit_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule
